// File: rtl/servo_tracker_if.sv
// Handshake bundle between the colour-detect pipeline, the servo tracker and the pan servo driver.
interface servo_tracker_if;
  logic        i_valid;
  logic [15:0] i_xPos;
  logic        o_start;
  logic [31:0] o_pulseWidth;
  logic        i_done;
  logic        o_busy;
  logic [15:0] o_dropCount;

  modport master (
    output i_valid, i_xPos, i_done,
    input  o_start, o_pulseWidth, o_busy, o_dropCount
  );

  modport slave (
    input  i_valid, i_xPos, i_done,
    output o_start, o_pulseWidth, o_busy, o_dropCount
  );
endinterface

// File: rtl/servo_tracker.sv
// Turns centroid X samples into clamped, proportional pulse-width commands for the pan servo driver.
// Samples arriving mid-command are held latest-wins in a single pending slot.
module servo_tracker #(
  parameter int T_CLK       = 10,
  parameter int IMG_WIDTH   = 640,
  parameter int DEADBAND    = 16,
  parameter int STEP_PER_PX = 156
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  servo_tracker_if.slave bus
);

  localparam int C_NEUTRAL = 1500000 / T_CLK;
  localparam int C_MIN     = 1000000 / T_CLK;
  localparam int C_MAX     = 2000000 / T_CLK;

  localparam logic [15:0]        X_MAX    = 16'(IMG_WIDTH - 1);
  localparam logic signed [16:0] X_CENTRE = 17'(IMG_WIDTH / 2);
  localparam logic signed [16:0] DB_POS   = 17'(DEADBAND);
  localparam logic signed [16:0] DB_NEG   = 17'(-DEADBAND);
  localparam logic signed [32:0] NEUTRAL_S = 33'(C_NEUTRAL);
  localparam logic signed [32:0] MIN_S     = 33'(C_MIN);
  localparam logic signed [32:0] MAX_S     = 33'(C_MAX);
  localparam logic signed [32:0] STEP_S    = 33'(STEP_PER_PX);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [15:0]        sample_x;
  logic [15:0]        pend_x;
  logic               pending;
  logic [15:0]        drop_count;
  logic [31:0]        pulse_width;
  logic [15:0]        x_clamped;
  logic signed [16:0] err;
  logic signed [32:0] prod;
  logic signed [32:0] pw_raw;
  logic [31:0]        pw_clamped;
  logic               in_deadband;
  logic               ret_idle;

  // Clamp happens on the full 33-bit signed sum so an overshoot can never wrap into range.
  always_comb begin
    x_clamped   = (sample_x > X_MAX) ? X_MAX : sample_x;
    err         = $signed({1'b0, x_clamped}) - X_CENTRE;
    prod        = $signed({{16{err[16]}}, err}) * STEP_S;
    pw_raw      = NEUTRAL_S + prod;
    in_deadband = (err <= DB_POS) && (err >= DB_NEG);
    if (pw_raw < MIN_S) begin
      pw_clamped = MIN_S[31:0];
    end else if (pw_raw > MAX_S) begin
      pw_clamped = MAX_S[31:0];
    end else begin
      pw_clamped = pw_raw[31:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ret_idle marks the cycle a command (or a deadband sample) finishes and the pending slot is consulted.
  always_comb begin
    next_state = state;
    ret_idle   = 1'b0;
    case (state)
      IDLE:      if (bus.i_valid) next_state = CALC;
      CALC:      if (in_deadband) ret_idle = 1'b1; else next_state = ISSUE;
      ISSUE:     next_state = WAIT_ACK;
      WAIT_ACK:  if (!bus.i_done) next_state = WAIT_DONE;
      WAIT_DONE: if (bus.i_done) ret_idle = 1'b1;
      default:   next_state = IDLE;
    endcase
    if (ret_idle) begin
      next_state = (pending || bus.i_valid) ? CALC : IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sample_x    <= '0;
      pend_x      <= '0;
      pending     <= 1'b0;
      drop_count  <= '0;
      pulse_width <= 32'(C_NEUTRAL);
    end else begin
      if (state == IDLE) begin
        if (bus.i_valid) sample_x <= bus.i_xPos;
      end else if (ret_idle && pending) begin
        sample_x <= pend_x;
        pending  <= bus.i_valid;
        if (bus.i_valid) pend_x <= bus.i_xPos;
      end else if (ret_idle && bus.i_valid) begin
        sample_x <= bus.i_xPos;
      end else if (bus.i_valid) begin
        pend_x  <= bus.i_xPos;
        pending <= 1'b1;
        if (pending && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
      if ((state == CALC) && !in_deadband) pulse_width <= pw_clamped;
    end
  end

  assign bus.o_start      = (state == ISSUE);
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_pulseWidth = pulse_width;
  assign bus.o_dropCount  = drop_count;

endmodule

// File: doc/servo_tracker.md
# servo_tracker

Upstream control stage for the pan servo driver. Consumes per-frame object centroid X positions from the colour-detect pipeline. Each off-centre sample becomes a proportional, clamped pulse-width command, issued to the driver through its start/done handshake. Samples that arrive while a command is in flight are buffered latest-wins, and overwrites are counted.

## Interface
- T_CLK, 10, clock period in ns; must match the driver.
- IMG_WIDTH, 640, frame width in pixels; centre is IMG_WIDTH/2.
- DEADBAND, 16, maximum absolute pixel error that produces no command.
- STEP_PER_PX, 156, clock cycles of pulse width per pixel of error.
- Derived constants:
  - C_NEUTRAL = 1500000/T_CLK
  - C_MIN = 1000000/T_CLK
  - C_MAX = 2000000/T_CLK
- i_clk  in  1  system clock.
- i_rstn  in  1  asynchronous, active-low reset.
- i_valid  in  1  single-cycle strobe, centroid sample present.
- i_xPos  in  16  centroid X in pixels, unsigned.
- o_start  out  1  one-cycle command strobe to driver.
- o_pulseWidth  out  32  commanded pulse width in clock cycles.
- i_done  in  1  driver idle/complete flag (high when idle).
- o_busy  out  1  high whenever state is not IDLE.
- o_dropCount  out  16  saturating count of overwritten samples.

## Operation
- States: IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE.
- Sample capture:
  - i_valid in IDLE loads the sample register and moves to CALC.
  - i_valid in any other state writes the pending register and sets pending.
  - If pending is already set, the new sample overwrites it and o_dropCount increments, saturating at 0xFFFF.
- CALC:
  - x = min(i_xPos, IMG_WIDTH-1).
  - e = x − IMG_WIDTH/2, signed 17 bits.
  - If |e| ≤ DEADBAND, no command is issued, o_pulseWidth is unchanged, and the FSM returns toward IDLE.
  - Otherwise, p = C_NEUTRAL + e·STEP_PER_PX in signed 33-bit arithmetic, clamped to [C_MIN, C_MAX], registered, then go to ISSUE.
- ISSUE: o_pulseWidth takes the clamped value and o_start is high for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: wait for i_done=0, then go to WAIT_DONE.
- WAIT_DONE: wait for i_done=1, then return toward IDLE.
- Return toward IDLE:
  - If pending=1, go to CALC using the pending sample and clear pending.
  - An i_valid in that same cycle refills pending and is not counted as a drop.
  - If pending=0, go to IDLE.
- o_pulseWidth is held stable between commands. The driver latches it on o_start.

## Timing
- Reset values:
  - o_start=0, o_pulseWidth=C_NEUTRAL, o_busy=0, o_dropCount=0.
  - pending=0, state=IDLE.
- Reset is asynchronous. Assertion mid-command immediately drops o_start and discards both the sample and pending registers.
- Latency:
  - i_valid sampled at cycle N (IDLE).
  - Cycle N+1 is CALC.
  - o_start is high during cycle N+2, with o_pulseWidth valid in the same cycle.
- Deadband sample: o_busy is high for 1 cycle (CALC) and there is no o_start.
- Driver handshake: the driver drops i_done one cycle after o_start and raises it after C_MAX cycles.
  - The block never asserts o_start while in WAIT_ACK or WAIT_DONE.
  - o_start is never asserted twice per command.
- Back-to-back: a pending sample produces its o_start 2 cycles after i_done rises.
- i_xPos ≥ IMG_WIDTH is treated as IMG_WIDTH−1.
- Arithmetic: the product is exact; the clamp is applied before truncation to 32 bits.

## Test plan
- Reset, then i_valid with i_xPos=320 → no o_start, o_pulseWidth stays 150000, o_busy high 1 cycle.
- i_xPos=420 (e=100) → o_start at N+2, o_pulseWidth=165600. Driver model drops i_done next cycle and raises it 200000 cycles later; FSM returns to IDLE.
- i_xPos=0 → o_pulseWidth=100080. i_xPos=639 → 199764. i_xPos=900 → same as 639.
- STEP_PER_PX=200, i_xPos=639 → clamped 200000. i_xPos=0 → clamped 100000.
- During WAIT_DONE, send i_xPos=500 then i_xPos=100 → o_dropCount=1. The only next command is for x=100 (o_pulseWidth=115680), issued 2 cycles after i_done rises.
- Assert i_rstn=0 mid-WAIT_DONE with pending set → outputs at reset values immediately. After release, there is no o_start until a new i_valid.
